// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: the program loader (writes) has priority
// over core fetch (reads), bounded by a starvation guard; fetch data returns 1 cycle later.
module imem_arbiter #(
    parameter int addr_width_p     = 10,
    parameter int max_load_burst_p = 4,
    parameter int instr_width_p    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_v_i,
    input  logic [addr_width_p-1:0]  load_addr_i,
    input  logic [instr_width_p-1:0] load_instr_i,
    output logic                     load_ready_o,
    input  logic                     fetch_v_i,
    input  logic [addr_width_p-1:0]  fetch_addr_i,
    output logic                     fetch_ready_o,
    output logic                     fetch_data_v_o,
    output logic [instr_width_p-1:0] fetch_instr_o,
    output logic [addr_width_p-1:0]  mem_addr_o,
    output logic [instr_width_p-1:0] mem_instr_o,
    output logic                     mem_wen_o,
    input  logic [instr_width_p-1:0] mem_instr_i,
    output logic                     busy_o
);

    localparam int cnt_w_lp = $clog2(max_load_burst_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(max_load_burst_p);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FETCH = 2'd2
    } grant_e;

    grant_e                grant_d, grant_q;
    logic [cnt_w_lp-1:0]   starve_d, starve_q;
    logic                  fetch_data_v_q;
    logic                  busy_q;

    // Arbitration: loader wins until fetch has waited max_load_burst_p grants.
    always_comb begin
        grant_d  = S_IDLE;
        starve_d = '0;
        if (load_v_i && fetch_v_i) begin
            if (starve_q < cnt_max_lp) begin
                grant_d  = S_LOAD;
                starve_d = starve_q + cnt_w_lp'(1);
            end else begin
                grant_d  = S_FETCH;
                starve_d = '0;
            end
        end else if (load_v_i) begin
            grant_d  = S_LOAD;
            starve_d = '0;
        end else if (fetch_v_i) begin
            grant_d  = S_FETCH;
            starve_d = '0;
        end else begin
            grant_d  = S_IDLE;
            starve_d = '0;
        end
    end

    // Memory pins and handshakes; nothing is granted while reset is held.
    always_comb begin
        load_ready_o  = 1'b0;
        fetch_ready_o = 1'b0;
        mem_wen_o     = 1'b0;
        mem_addr_o    = fetch_addr_i;
        mem_instr_o   = '0;
        if (reset) begin
            load_ready_o  = 1'b0;
            fetch_ready_o = 1'b0;
        end else begin
            case (grant_d)
                S_LOAD: begin
                    load_ready_o = 1'b1;
                    mem_wen_o    = 1'b1;
                    mem_addr_o   = load_addr_i;
                    mem_instr_o  = load_instr_i;
                end
                S_FETCH: begin
                    fetch_ready_o = 1'b1;
                end
                default: begin
                    load_ready_o  = 1'b0;
                    fetch_ready_o = 1'b0;
                end
            endcase
        end
    end

    // Grant history, starvation counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q        <= S_IDLE;
            starve_q       <= '0;
            fetch_data_v_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            grant_q        <= grant_d;
            starve_q       <= starve_d;
            fetch_data_v_q <= (grant_d == S_FETCH);
            busy_q         <= (grant_d == S_LOAD);
        end
    end

    // The memory registers its read data, so it already lines up with data_v.
    assign fetch_instr_o  = mem_instr_i;
    assign fetch_data_v_o = fetch_data_v_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural instr_mem and a scoreboard
// queue of expected fetch data drained by an independent monitor.
module tb_imem_arbiter;

    localparam int AW = 10;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_v_i, fetch_v_i;
    logic [AW-1:0] load_addr_i, fetch_addr_i;
    logic [IW-1:0] load_instr_i;
    logic          load_ready_o, fetch_ready_o, fetch_data_v_o, mem_wen_o, busy_o;
    logic [IW-1:0] fetch_instr_o, mem_instr_o, mem_instr_i;
    logic [AW-1:0] mem_addr_o;

    logic [IW-1:0] mem [0:(1<<AW)-1];
    logic [IW-1:0] exp_q [$];
    int            checks   = 0;
    int            failures = 0;

    imem_arbiter #(.addr_width_p(AW), .max_load_burst_p(4), .instr_width_p(IW)) dut (
        .clk(clk), .reset(reset),
        .load_v_i(load_v_i), .load_addr_i(load_addr_i), .load_instr_i(load_instr_i),
        .load_ready_o(load_ready_o),
        .fetch_v_i(fetch_v_i), .fetch_addr_i(fetch_addr_i), .fetch_ready_o(fetch_ready_o),
        .fetch_data_v_o(fetch_data_v_o), .fetch_instr_o(fetch_instr_o),
        .mem_addr_o(mem_addr_o), .mem_instr_o(mem_instr_o), .mem_wen_o(mem_wen_o),
        .mem_instr_i(mem_instr_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Synchronous single-port instruction memory
    always @(posedge clk) begin
        if (mem_wen_o) mem[mem_addr_o] <= mem_instr_o;
        mem_instr_i <= mem[mem_addr_o];
    end

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every data_v beat must match the oldest expected fetch.
    always @(negedge clk) begin
        if (fetch_data_v_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_data_v", 32'd1, 32'd0);
            end else begin
                chk("fetch_data", fetch_instr_o, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        load_v_i = 1'b0; fetch_v_i = 1'b0;
        load_addr_i = '0; load_instr_i = '0; fetch_addr_i = '0;
    endtask

    string exp_grant;
    string got;
    logic [AW-1:0] ld_addr;

    initial begin
        reset = 1'b1;
        idle_in();
        step();
        // Requests while in reset are refused and nothing is driven
        load_v_i = 1'b1; fetch_v_i = 1'b1; load_addr_i = 10'h3FF; load_instr_i = 32'hDEAD;
        #2;
        chk("rst_load_ready", {31'd0, load_ready_o}, 32'd0);
        chk("rst_fetch_ready", {31'd0, fetch_ready_o}, 32'd0);
        chk("rst_wen", {31'd0, mem_wen_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_data_v", {31'd0, fetch_data_v_o}, 32'd0);
        step();
        reset = 1'b0;
        idle_in();

        // Test 1: fetch accepted, reset asserted just after the accepting edge
        step();
        fetch_v_i = 1'b1; fetch_addr_i = 10'd0;
        #2;
        chk("t1_fetch_ready", {31'd0, fetch_ready_o}, 32'd1);
        step();
        reset = 1'b1; fetch_v_i = 1'b0; load_v_i = 1'b1; load_addr_i = 10'd1;
        #2;
        chk("t1_data_v", {31'd0, fetch_data_v_o}, 32'd0);
        chk("t1_busy", {31'd0, busy_o}, 32'd0);
        chk("t1_wen", {31'd0, mem_wen_o}, 32'd0);
        chk("t1_load_ready", {31'd0, load_ready_o}, 32'd0);
        step();
        chk("t1_wen_held", {31'd0, mem_wen_o}, 32'd0);
        reset = 1'b0;
        idle_in();

        // Test 2: back-to-back loads
        step();
        load_v_i = 1'b1; load_addr_i = 10'h3; load_instr_i = 32'hA5;
        #2;
        chk("t2_ready0", {31'd0, load_ready_o}, 32'd1);
        chk("t2_wen0", {31'd0, mem_wen_o}, 32'd1);
        chk("t2_addr0", {22'd0, mem_addr_o}, 32'h3);
        chk("t2_instr0", mem_instr_o, 32'hA5);
        step();
        load_addr_i = 10'h4; load_instr_i = 32'h5A;
        #2;
        chk("t2_ready1", {31'd0, load_ready_o}, 32'd1);
        chk("t2_wen1", {31'd0, mem_wen_o}, 32'd1);
        chk("t2_busy", {31'd0, busy_o}, 32'd1);
        chk("t2_instr1", mem_instr_o, 32'h5A);
        step();
        idle_in();

        // Test 3: back-to-back fetches of the just-written words
        step();
        fetch_v_i = 1'b1; fetch_addr_i = 10'h3;
        #2;
        chk("t3_ready0", {31'd0, fetch_ready_o}, 32'd1);
        chk("t3_wen0", {31'd0, mem_wen_o}, 32'd0);
        exp_q.push_back(32'hA5);
        step();
        fetch_addr_i = 10'h4;
        #2;
        chk("t3_ready1", {31'd0, fetch_ready_o}, 32'd1);
        exp_q.push_back(32'h5A);
        step();
        idle_in();
        step();

        // Test 4: continuous contention, burst limit 4
        exp_grant = "LLLLFLLLLFLLLLF";
        got = "";
        ld_addr = 10'h20;
        for (int i = 0; i < exp_grant.len(); i++) begin
            load_v_i = 1'b1; load_addr_i = ld_addr; load_instr_i = 32'h100 + 32'(ld_addr);
            fetch_v_i = 1'b1; fetch_addr_i = 10'h3;
            #2;
            checks++;
            if (load_ready_o && fetch_ready_o) begin
                failures++;
                $display("FAIL t4_exclusive: both ready in slot %0d", i);
            end
            chk("t4_wen_vs_load", {31'd0, mem_wen_o}, {31'd0, load_ready_o});
            if (load_ready_o) begin
                got = {got, "L"};
                ld_addr = ld_addr + 10'd1;
            end else if (fetch_ready_o) begin
                got = {got, "F"};
                exp_q.push_back(32'hA5);
            end else begin
                got = {got, "-"};
            end
            step();
        end
        checks++;
        if (got != exp_grant) begin
            failures++;
            $display("FAIL t4_grants: got %s expected %s", got, exp_grant);
        end
        idle_in();
        step();

        // Test 5: write then read of the same address in consecutive cycles
        load_v_i = 1'b1; load_addr_i = 10'h7; load_instr_i = 32'h1234;
        #2;
        chk("t5_load_ready", {31'd0, load_ready_o}, 32'd1);
        step();
        idle_in();
        fetch_v_i = 1'b1; fetch_addr_i = 10'h7;
        #2;
        chk("t5_fetch_ready", {31'd0, fetch_ready_o}, 32'd1);
        exp_q.push_back(32'h1234);
        step();
        idle_in();

        // Test 6: idle cycles
        for (int i = 0; i < 10; i++) begin
            step();
            #2;
            chk("t6_wen", {31'd0, mem_wen_o}, 32'd0);
            chk("t6_data_v", {31'd0, fetch_data_v_o}, 32'd0);
            chk("t6_busy", {31'd0, busy_o}, 32'd0);
        end

        // Counter must have cleared: contention again starts a fresh burst
        got = "";
        for (int i = 0; i < 5; i++) begin
            step();
            load_v_i = 1'b1; load_addr_i = 10'h40 + 10'(i); load_instr_i = 32'h77;
            fetch_v_i = 1'b1; fetch_addr_i = 10'h4;
            #2;
            if (load_ready_o) got = {got, "L"};
            else if (fetch_ready_o) begin
                got = {got, "F"};
                exp_q.push_back(32'h5A);
            end else got = {got, "-"};
        end
        exp_grant = "LLLLF";
        checks++;
        if (got != exp_grant) begin
            failures++;
            $display("FAIL t6_regrant: got %s expected %s", got, exp_grant);
        end
        step();
        idle_in();
        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
